funmin_table_eval: RTL and testbench

- Parametrised successor to the fixed 4-input minimised-function block.
- Holds an N_IN-input Boolean function as a 2^N_IN-entry truth table, loaded serially.
- Evaluates the function on a live input vector with a registered output.
- On request, sweeps every input combination and reports onset size plus constant-0/constant-1 flags.
- Used as a reconfigurable logic cell and as a self-check engine for minimisation experiments.

---
 rtl/funmin_table_eval.sv | 103 ++++++++++
 tb/tb_funmin_table_eval.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/funmin_table_eval.sv
// Reconfigurable N_IN-input logic cell: serially loaded truth table, registered
// evaluation, and an exhaustive onset-count sweep with constant-function flags.
//
// state | meaning
// IDLE  | table may be loaded; sweep_start accepted when no load is active
// SWEEP | one table entry added to the accumulator per cycle, table frozen
// DONE  | one-cycle sweep_done pulse, results just registered
module funmin_table_eval #(
  parameter int N_IN = 4,
  localparam int TW = 1 << N_IN,
  localparam int CW = N_IN + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_start,
  input  logic            load_valid,
  input  logic            load_bit,
  output logic            table_ready,
  input  logic [N_IN-1:0] inp,
  output logic            out,
  input  logic            sweep_start,
  output logic            busy,
  output logic            sweep_done,
  output logic [CW-1:0]   onset_cnt,
  output logic            const0,
  output logic            const1
);

  localparam logic [CW-1:0]   CNT_FULL = CW'(TW);
  localparam logic [N_IN-1:0] IDX_LAST = {N_IN{1'b1}};

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t          state;
  logic [TW-1:0]   tbl;
  logic [CW-1:0]   load_cnt;
  logic [CW-1:0]   acc;
  logic [CW-1:0]   sum;
  logic [N_IN-1:0] idx;

  assign sum = acc + {{(CW-1){1'b0}}, tbl[idx]};

  // Evaluation is independent of the sweep and of table_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) out <= 1'b0;
    else     out <= tbl[inp];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      tbl         <= '0;
      load_cnt    <= '0;
      table_ready <= 1'b0;
      busy        <= 1'b0;
      sweep_done  <= 1'b0;
      onset_cnt   <= '0;
      const0      <= 1'b0;
      const1      <= 1'b0;
      acc         <= '0;
      idx         <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Load has priority; a coincident sweep_start is dropped.
          if (load_start || load_valid) begin
            if (load_valid) tbl <= {tbl[TW-2:0], load_bit};
            if (load_start) begin
              load_cnt    <= load_valid ? CW'(1) : '0;
              table_ready <= 1'b0;
            end else if (load_cnt != CNT_FULL) begin
              load_cnt    <= load_cnt + CW'(1);
              table_ready <= (load_cnt + CW'(1)) == CNT_FULL;
            end
          end else if (sweep_start) begin
            state <= SWEEP;
            busy  <= 1'b1;
            idx   <= '0;
            acc   <= '0;
          end
        end
        SWEEP: begin
          acc <= sum;
          idx <= idx + N_IN'(1);
          if (idx == IDX_LAST) begin
            state      <= DONE;
            busy       <= 1'b0;
            sweep_done <= 1'b1;
            onset_cnt  <= sum;
            const0     <= (sum == '0);
            const1     <= (sum == CNT_FULL);
          end
        end
        DONE: begin
          sweep_done <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_funmin_table_eval.sv
// Directed and randomized bench for funmin_table_eval (N_IN=4 and N_IN=2 instances)
// against a truth-table reference model held as a plain bit vector.
module tb_funmin_table_eval;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       ls, lv, lb, ss;
  logic [3:0] inp;
  logic       tr, o, bsy, sd, c0, c1;
  logic [4:0] oc;

  logic       ls2, lv2, lb2, ss2;
  logic [1:0] inp2;
  logic       tr2, o2, bsy2, sd2, c02, c12;
  logic [2:0] oc2;

  funmin_table_eval #(.N_IN(4)) dut4 (
    .clk(clk), .rst(rst), .load_start(ls), .load_valid(lv), .load_bit(lb),
    .table_ready(tr), .inp(inp), .out(o), .sweep_start(ss), .busy(bsy),
    .sweep_done(sd), .onset_cnt(oc), .const0(c0), .const1(c1));

  funmin_table_eval #(.N_IN(2)) dut2 (
    .clk(clk), .rst(rst), .load_start(ls2), .load_valid(lv2), .load_bit(lb2),
    .table_ready(tr2), .inp(inp2), .out(o2), .sweep_start(ss2), .busy(bsy2),
    .sweep_done(sd2), .onset_cnt(oc2), .const0(c02), .const1(c12));

  int checks = 0;
  int errors = 0;

  // Reference model: current table contents and bits loaded since load_start.
  logic [15:0] tbl_m;
  int          cnt_m;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic shift_bit(input logic b, input logic with_start);
    lv = 1'b1; lb = b; ls = with_start;
    tick;
    lv = 1'b0; ls = 1'b0;
    tbl_m = {tbl_m[14:0], b};
    cnt_m = with_start ? 1 : ((cnt_m < 16) ? cnt_m + 1 : 16);
    chk("table_ready", 32'(tr), 32'(cnt_m == 16));
  endtask

  task automatic load_word(input logic [15:0] w);
    ls = 1'b1;
    tick;
    ls = 1'b0;
    cnt_m = 0;
    chk("ready_cleared", 32'(tr), 32'(0));
    for (int i = 15; i >= 0; i--) shift_bit(w[i], 1'b0);
  endtask

  task automatic eval(input logic [3:0] v);
    inp = v;
    tick;
    chk("out", 32'(o), 32'(tbl_m[v]));
  endtask

  task automatic sweep(input bit noise);
    int         exp;
    logic [3:0] li;
    exp = $countones(tbl_m);
    ss = 1'b1; li = inp;
    tick;
    ss = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk("busy", 32'(bsy), 32'(1));
      chk("done_early", 32'(sd), 32'(0));
      chk("out_in_sweep", 32'(o), 32'(tbl_m[li]));
      li = 4'($urandom); inp = li;
      if (noise) begin
        lv = 1'b1; lb = 1'b1; ls = (k == 3); ss = (k == 5);
      end
      tick;
    end
    lv = 1'b0; ls = 1'b0; ss = 1'b0;
    chk("sweep_done", 32'(sd), 32'(1));
    chk("busy_end", 32'(bsy), 32'(0));
    chk("onset_cnt", 32'(oc), 32'(exp));
    chk("const0", 32'(c0), 32'(exp == 0));
    chk("const1", 32'(c1), 32'(exp == 16));
    tick;
    chk("done_pulse_end", 32'(sd), 32'(0));
    chk("onset_hold", 32'(oc), 32'(exp));
    chk("ready_hold", 32'(tr), 32'(cnt_m == 16));
    tick;
    chk("no_second_done", 32'(sd), 32'(0));
    chk("idle_after", 32'(bsy), 32'(0));
  endtask

  initial begin
    logic [3:0] w2;
    logic [3:0] vals [4];
    rst = 1'b1;
    ls = 0; lv = 0; lb = 0; ss = 0; inp = '0;
    ls2 = 0; lv2 = 0; lb2 = 0; ss2 = 0; inp2 = '0;
    tbl_m = '0; cnt_m = 0;
    #12;
    chk("rst_ready", 32'(tr), 32'(0));
    chk("rst_out", 32'(o), 32'(0));
    chk("rst_busy", 32'(bsy), 32'(0));
    chk("rst_done", 32'(sd), 32'(0));
    chk("rst_onset", 32'(oc), 32'(0));
    chk("rst_c0", 32'(c0), 32'(0));
    chk("rst_c1", 32'(c1), 32'(0));
    tick;
    rst = 1'b0;
    tick;

    // Directed 0x0F0F load and evaluation.
    load_word(16'h0F0F);
    vals = '{4'd5, 4'd2, 4'd9, 4'd15};
    foreach (vals[i]) eval(vals[i]);
    sweep(1'b0);
    load_word(16'hFFFF);
    sweep(1'b0);
    load_word(16'h0000);
    sweep(1'b0);

    // Sweep with load activity and a second sweep_start while busy.
    load_word(16'hA5C3);
    sweep(1'b1);
    for (int i = 0; i < 4; i++) eval(4'($urandom));

    // Extra bits past a full table keep shifting; ready stays high.
    for (int i = 0; i < 3; i++) shift_bit(1'($urandom), 1'b0);
    for (int i = 0; i < 3; i++) eval(4'($urandom));

    // Coincident load_start and load_valid restarts the count at one.
    shift_bit(1'b1, 1'b1);
    for (int i = 0; i < 15; i++) shift_bit(1'($urandom), 1'b0);
    eval(4'd0);

    // sweep_start coincident with a load is dropped, not queued.
    lv = 1'b1; lb = 1'b0; ss = 1'b1;
    tick;
    lv = 1'b0; ss = 1'b0;
    tbl_m = {tbl_m[14:0], 1'b0};
    chk("sweep_dropped", 32'(bsy), 32'(0));
    tick;
    chk("sweep_not_queued", 32'(bsy), 32'(0));

    // Randomized tables.
    for (int r = 0; r < 5; r++) begin
      load_word(16'($urandom));
      for (int i = 0; i < 4; i++) eval(4'($urandom));
      sweep(1'($urandom));
    end

    // Asynchronous reset in the sixth busy cycle.
    load_word(16'hF0F0);
    sweep(1'b0);
    eval(4'd15);
    ss = 1'b1;
    tick;
    ss = 1'b0;
    repeat (5) tick;
    chk("busy_before_rst", 32'(bsy), 32'(1));
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(bsy), 32'(0));
    chk("arst_out", 32'(o), 32'(0));
    chk("arst_onset", 32'(oc), 32'(0));
    chk("arst_ready", 32'(tr), 32'(0));
    tbl_m = '0; cnt_m = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick;
      chk("no_done_after_rst", 32'(sd), 32'(0));
    end
    eval(4'd15);
    eval(4'd4);

    // N_IN=2 instance: AND function.
    w2 = 4'b1000;
    ls2 = 1'b1;
    tick;
    ls2 = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      lv2 = 1'b1; lb2 = w2[i];
      tick;
    end
    lv2 = 1'b0;
    chk("n2_ready", 32'(tr2), 32'(1));
    for (int i = 0; i < 4; i++) begin
      inp2 = 2'(i);
      tick;
      chk("n2_out", 32'(o2), 32'(w2[i]));
    end
    ss2 = 1'b1;
    tick;
    ss2 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("n2_busy", 32'(bsy2), 32'(1));
      chk("n2_done_early", 32'(sd2), 32'(0));
      tick;
    end
    chk("n2_done", 32'(sd2), 32'(1));
    chk("n2_onset", 32'(oc2), 32'(1));
    chk("n2_c0", 32'(c02), 32'(0));
    chk("n2_c1", 32'(c12), 32'(0));
    tick;
    chk("n2_done_end", 32'(sd2), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
